// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared state encoding and byte-strobe helpers for the data-memory responder
//
// Contents:
//   state_t      responder FSM states (ST_IDLE, ST_BUSY, ST_DONE)
//   WEN_*        byte write strobe encodings a load/store may legally issue
//   wen_legal()  1 when a strobe is a byte, aligned half, full word or plain read
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [3:0] WEN_READ = 4'b0000;
    localparam logic [3:0] WEN_B0   = 4'b0001;
    localparam logic [3:0] WEN_B1   = 4'b0010;
    localparam logic [3:0] WEN_B2   = 4'b0100;
    localparam logic [3:0] WEN_B3   = 4'b1000;
    localparam logic [3:0] WEN_HLO  = 4'b0011;
    localparam logic [3:0] WEN_HHI  = 4'b1100;
    localparam logic [3:0] WEN_WORD = 4'b1111;

    function automatic logic wen_legal(input logic [3:0] wen);
        logic ok;
        case (wen)
            WEN_READ, WEN_B0, WEN_B1, WEN_B2, WEN_B3,
            WEN_HLO, WEN_HHI, WEN_WORD: ok = 1'b1;
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - word-wide data store with per-byte write and registered read-first port
//
// Ports:
//   clk    in   1           rising-edge clock
//   we     in   4           byte write enables for the addressed word
//   idx    in   DEPTH_LOG2  word index
//   wdata  in   32          byte-lane aligned write data
//   rdata  out  32          word at idx as it was before this edge's write
module dmem_bank #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] r_mem [2**DEPTH_LOG2];

    // Contents survive reset; rdata samples the pre-write word (read-first).
    always_ff @(posedge clk) begin
        rdata <= r_mem[idx];
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                r_mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data-memory responder that stalls the pipeline until the access completes
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   req_en     in   1   load/store request from the mem stage
//   req_wen    in   4   byte write strobe, 0000 = read
//   req_addr   in   32  byte address
//   req_wdata  in   32  byte-lane aligned write data
//   rsp_rdata  out  32  aligned read word, held until the next completion
//   rsp_valid  out  1   one-cycle completion pulse
//   rsp_stall  out  1   pipeline freeze request
//   addr_err   out  1   completion carried an illegal strobe or out-of-window address
module dmem_responder #(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rsp_rdata,
    output logic        rsp_valid,
    output logic        rsp_stall,
    output logic        addr_err
);

    import mips_mem_pkg::*;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_accept;
    logic                  w_commit;

    logic [31:0]           r_addr;
    logic [3:0]            r_wen;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rsp_rdata;

    logic [31:0]           w_off;
    logic                  w_in_win;
    logic                  w_err;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [3:0]            w_bank_we;
    logic [31:0]           w_bank_rdata;
    logic [31:0]           w_done_rdata;

    // Window test on the unsigned offset: addresses below BASE_ADDR wrap to a
    // large offset and fail the same high-bits-zero test as those above it.
    assign w_off    = r_addr - BASE_ADDR;
    assign w_in_win = (w_off >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign w_idx    = w_off[DEPTH_LOG2+1:2];
    assign w_err    = !w_in_win || !wen_legal(r_wen);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        rsp_stall   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_en) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = CNT_INIT;
                    w_state_nxt = ST_BUSY;
                    rsp_stall   = 1'b1;
                end
            end
            ST_BUSY: begin
                rsp_stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            // req_en seen here is the same request held by the stall; never re-accept it.
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (rst) begin
            rsp_stall = 1'b0;
        end
    end

    // A reset landing on the commit edge must drop the write.
    assign w_bank_we = (w_commit && !w_err && !rst) ? r_wen : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= 32'd0;
            r_wen       <= 4'd0;
            r_wdata     <= 32'd0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wen   <= req_wen;
                r_wdata <= req_wdata;
            end
            // The bank port keeps reading every cycle, so park the completed word here.
            if (r_state == ST_DONE) begin
                r_rsp_rdata <= w_done_rdata;
            end
        end
    end

    dmem_bank #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_bank (
        .clk   (clk),
        .we    (w_bank_we),
        .idx   (w_idx),
        .wdata (r_wdata),
        .rdata (w_bank_rdata)
    );

    assign w_done_rdata = w_err ? 32'd0 : w_bank_rdata;
    assign rsp_rdata    = (r_state == ST_DONE) ? w_done_rdata : r_rsp_rdata;
    assign rsp_valid    = (r_state == ST_DONE);
    assign addr_err     = rsp_valid && w_err;

endmodule
